plot_receiver: RTL and testbench
================================

PLOT_RECEIVER -- requirements
Module: plot_receiver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning plot FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter FB_W, default 160, meaning framebuffer width in pixels.
REQ-003 The block SHALL have parameter FB_H, default 120, meaning framebuffer height in pixels.
REQ-004 clk  input  1  system clock; the block SHALL use one clock, and all logic SHALL be on its rising edge.
REQ-005 reset  input  1  reset; it SHALL be synchronous and active-high.
REQ-006 plot  input  1  plot command valid.
REQ-007 x  input  8  pixel column.
REQ-008 y  input  7  pixel row.
REQ-009 colour  input  3  RGB pixel colour.
REQ-010 ready  output  1  command accepted when plot&&ready.
REQ-011 clear  input  1  single-cycle request to fill the framebuffer with clear_colour.
REQ-012 clear_colour  input  3  fill colour, sampled when clear is accepted.
REQ-013 clear_done  output  1  one-cycle pulse at the end of a fill.
REQ-014 rd_req  input  1  scan-out read request; it SHALL take highest priority.
REQ-015 rd_addr  input  15  scan-out read address.
REQ-016 mem_addr  output  15  framebuffer address, registered.
REQ-017 mem_data  output  3  framebuffer write data, registered.
REQ-018 mem_we  output  1  framebuffer write enable, registered.
REQ-019 drop_count  output  8  saturating count of clipped commands.

Function
REQ-020 ready SHALL equal !fifo_full && state!=CLEAR.
- plot while ready==0: ignored, no side effect.
REQ-021 An accepted command SHALL be pushed to the FIFO as {addr, colour}.
- addr = y*FB_W + x, computed as (y<<7)+(y<<5)+x, 15 bits, no truncation for in-range inputs.
REQ-022 The FSM SHALL have states IDLE, DRAIN, CLEAR.
- IDLE->DRAIN: FIFO non-empty.
- DRAIN->IDLE: FIFO empties with no pending clear.
- IDLE->CLEAR: pending clear and FIFO empty.
- CLEAR->IDLE: after the final address is written.
REQ-023 In each cycle the memory port SHALL be granted in strict priority rd_req > CLEAR sweep > FIFO pop.
REQ-024 A rd_req cycle SHALL drive the next cycle's outputs as mem_addr=rd_addr, mem_we=0.
- It SHALL stall the sweep counter and FIFO pop, with no loss.
REQ-025 A granted FIFO pop SHALL produce mem_we=1, mem_addr=entry addr, mem_data=entry colour on the following cycle.
- A plot accepted into an empty FIFO at cycle N SHALL appear on the memory outputs in cycle N+2 when unstalled.
REQ-026 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged.
- Entries SHALL be written in strict acceptance order.
REQ-027 A clear arriving in DRAIN or IDLE with the FIFO non-empty SHALL be latched pending.
- The FIFO SHALL drain first.
- A second clear while one is pending or active SHALL be ignored.
REQ-028 CLEAR SHALL write addresses 0..FB_W*FB_H-1 (0..19199) in ascending order, one per granted cycle.
- It SHALL use the latched clear_colour.
- Unstalled, it SHALL take exactly 19200 cycles.
REQ-029 clear_done SHALL pulse one cycle, coincident with the cycle after the mem_we for address 19199.
REQ-030 mem_we SHALL be 0 in every cycle with no granted write.

Reset
REQ-031 On reset the following SHALL clear:
- FIFO emptied, state=IDLE, pending clear cleared, sweep counter=0.
- mem_we=0, mem_addr=0, mem_data=0, clear_done=0, drop_count=0.
- ready=1 on the first cycle after reset deasserts.
REQ-032 Reset during CLEAR or DRAIN SHALL abort the operation immediately.
- No clear_done SHALL be produced for an aborted fill.

Configuration
REQ-033 With PLOT_CLIP_EN defined, a plot with x>=FB_W or y>=FB_H SHALL be accepted (ready semantics unchanged) but not pushed.
- drop_count SHALL increment, saturating at 255.
REQ-034 Without PLOT_CLIP_EN, every accepted plot SHALL be pushed with the address truncated to 15 bits, and drop_count SHALL be tied to 0.

Structure
REQ-035 A shared package plot_pkg SHALL hold the following:
- State encoding (IDLE/CLEAR/DRAIN).
- FB_W/FB_H defaults, FB_SIZE=19200.
- ADDR_W=15, COLOUR_W=3.
REQ-036 The FIFO SHALL be one sub-module plot_fifo, which has:
- push/pop/full/empty.
- Registered read data.
- Parameter DEPTH.

Verification
REQ-037 Reset, then plot x=3,y=2,colour=3'b101 at cycle N -> mem_we=1, mem_addr=323, mem_data=3'b101 at cycle N+2.
REQ-038 Five back-to-back plots with rd_req held high -> ready=0 on the fifth cycle with the FIFO full (DEPTH=4); release rd_req -> four writes in order, then ready=1.
REQ-039 clear with clear_colour=3'b010, no rd_req -> 19200 consecutive writes addr 0..19199 data 3'b010, clear_done one cycle after the last write, ready=0 throughout.
REQ-040 With PLOT_CLIP_EN, plot x=160,y=5 and x=10,y=120 -> no mem_we, drop_count=2; 300 such plots -> drop_count=255.
REQ-041 Two plots queued, then clear -> both plot writes occur before address 0 of the fill.
REQ-042 Reset asserted mid-fill at sweep address 5000 -> mem_we=0 next cycle, no clear_done, ready=1 after reset deasserts.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and constants for the plot receiver: FSM encoding,
// framebuffer geometry defaults and bus widths.
package plot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;
  localparam int FB_SIZE  = FB_W_DEF * FB_H_DEF;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int ENTRY_W  = ADDR_W + COLOUR_W;

  // Linear framebuffer address y*fb_w + x. For the default width this is
  // (y<<7)+(y<<5)+x; the constant multiply reduces to that shift-add.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] px,
                                                   input logic [6:0] py,
                                                   input int fb_w);
    pixel_addr = ADDR_W'(int'(py) * fb_w + int'(px));
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Plot command FIFO. Power-of-two depth, registered head-of-queue output:
// rd_data always holds the oldest entry whenever the FIFO is non-empty.
// Callers must not push when full or pop when empty.
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_rd_data;
  logic [AW-1:0] w_rd_ptr_nxt;

  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign rd_data      = r_rd_data;
  assign w_rd_ptr_nxt = pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  // Storage array, written on push; no reset needed for the data itself.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the registered head entry. When a push lands
  // in the slot that becomes the head, forward the incoming data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (push && (r_wr_ptr == w_rd_ptr_nxt)) r_rd_data <= wr_data;
      else                                    r_rd_data <= r_mem[w_rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/plot_receiver.sv
// Plot receiver: queues pixel plot commands, drains them to a framebuffer
// port, and sweeps the whole framebuffer on a clear request. The memory
// port is shared: scan-out read > clear sweep > FIFO pop.
// Optional build macro PLOT_CLIP_EN: drop (and count) off-screen plots.
//
// state | meaning
// IDLE  | nothing in flight; waits for queued plots or a pending clear
// DRAIN | FIFO holds plots being written out
// CLEAR | sweeping every framebuffer address with the latched colour
module plot_receiver
  import plot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FB_W  = FB_W_DEF,
  parameter int FB_H  = FB_H_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                ready,
  input  logic                clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_done,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  output logic [7:0]          drop_count
);

  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(FB_W * FB_H - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pend;
  logic [ADDR_W-1:0]   r_sweep;
  logic [COLOUR_W-1:0] r_clr_col;
  logic                r_last_q;
  logic                r_done;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_sweep;
  logic                w_sweep_last;
  logic                w_clear_acc;
  logic [ENTRY_W-1:0]  w_head;

  assign ready       = !w_full && (r_state != CLEAR);
  assign w_accept    = plot && ready;
  assign w_clear_acc = clear && !r_pend && (r_state != CLEAR);
  assign clear_done  = r_done;

`ifdef PLOT_CLIP_EN
  logic       w_clip;
  logic [7:0] r_drop;

  assign w_clip     = (int'(x) >= FB_W) || (int'(y) >= FB_H);
  assign w_push     = w_accept && !w_clip;
  assign drop_count = r_drop;

  // Saturating count of accepted-but-clipped plots.
  always_ff @(posedge clk) begin
    if (reset)                                     r_drop <= '0;
    else if (w_accept && w_clip && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end
`else
  assign w_push     = w_accept;
  assign drop_count = '0;
`endif

  plot_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .wr_data ({pixel_addr(x, y, FB_W), colour}),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Port arbitration and next-state. Pops are allowed in IDLE as well so a
  // plot reaches memory without waiting for the IDLE->DRAIN step.
  always_comb begin
    w_state_nxt  = r_state;
    w_sweep      = 1'b0;
    w_pop        = 1'b0;
    if (!rd_req) begin
      if (r_state == CLEAR) w_sweep = 1'b1;
      else if (!w_empty)    w_pop   = 1'b1;
    end
    w_sweep_last = w_sweep && (r_sweep == SWEEP_LAST);
    case (r_state)
      IDLE: begin
        if (r_pend && w_empty) w_state_nxt = CLEAR;
        else if (!w_empty)     w_state_nxt = DRAIN;
      end
      DRAIN:   if (w_empty)      w_state_nxt = IDLE;
      CLEAR:   if (w_sweep_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Clear request latch, sweep counter and the delayed completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_sweep   <= '0;
      r_clr_col <= '0;
      r_last_q  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_clear_acc) begin
        r_pend    <= 1'b1;
        r_clr_col <= clear_colour;
      end else if (w_state_nxt == CLEAR && r_state == IDLE) begin
        r_pend <= 1'b0;
      end
      if (w_sweep) r_sweep <= w_sweep_last ? '0 : r_sweep + ADDR_W'(1);
      r_last_q <= w_sweep_last;
      r_done   <= r_last_q;
    end
  end

  // Registered memory port; address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= w_sweep || w_pop;
      if (rd_req) begin
        mem_addr <= rd_addr;
      end else if (w_sweep) begin
        mem_addr <= r_sweep;
        mem_data <= r_clr_col;
      end else if (w_pop) begin
        mem_addr <= w_head[ENTRY_W-1:COLOUR_W];
        mem_data <= w_head[COLOUR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_plot_receiver.sv
// Scoreboard bench for plot_receiver. The stimulus side predicts every
// framebuffer write from the pixel rules (y*160+x, full-screen fills) and
// queues it; the monitor pops and compares whenever mem_we is seen.
`timescale 1ns/1ps
module tb_plot_receiver;

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        plot = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic [2:0]  colour = '0;
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        rd_req = 1'b0;
  logic [14:0] rd_addr = '0;
  logic        ready;
  logic        clear_done;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic [7:0]  drop_count;

  typedef struct {
    int addr;
    int data;
    bit fill;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e_w;
  int          checks = 0;
  int          failures = 0;
  int          exp_drops = 0;
  int          cyc = 0;
  int          fill0_cyc = 0;
  bit          exp_done = 1'b0;
  bit          next_done = 1'b0;
  bit          prev_rd = 1'b0;
  logic [14:0] prev_rd_addr = '0;
  bit          clip_on;

  always #5 clk = ~clk;

  plot_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .ready        (ready),
    .clear        (clear),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .drop_count   (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: every accepted on-screen plot becomes one write.
  always @(negedge clk) begin
    if (reset) begin
      exp_drops = 0;
    end else if (plot && ready) begin
      if (!clip_on || (int'(x) < FB_W && int'(y) < FB_H))
        exp_q.push_back('{addr: (int'(y) * FB_W + int'(x)) % 32768, data: int'(colour), fill: 1'b0});
      else if (exp_drops < 255)
        exp_drops++;
    end
  end

  // Monitor: compares each presented memory cycle with the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
      prev_rd  = 1'b0;
    end else begin
      next_done = 1'b0;
      if (prev_rd) begin
        check("rd_we", 32'(mem_we), 0);
        check("rd_addr", 32'(mem_addr), 32'(prev_rd_addr));
      end else if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_we), 0);
        end else begin
          e_w = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), e_w.addr);
          check("wr_data", 32'(mem_data), e_w.data);
          if (e_w.fill && e_w.addr == 0) fill0_cyc = cyc;
          if (e_w.fill && e_w.addr != FB_SIZE - 1) check("ready_in_fill", 32'(ready), 0);
          next_done = e_w.fill && (e_w.addr == FB_SIZE - 1);
        end
      end
      if (clear_done || exp_done) begin
        check("clear_done", 32'(clear_done), 32'(exp_done));
        if (exp_done) check("fill_cycles", cyc - fill0_cyc, FB_SIZE);
      end
      exp_done     = next_done;
      prev_rd      = rd_req;
      prev_rd_addr = rd_addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_clear(input logic [2:0] col);
    clear        = 1'b1;
    clear_colour = col;
    for (int a = 0; a < FB_SIZE; a++) exp_q.push_back('{addr: a, data: int'(col), fill: 1'b1});
    tick;
    clear        = 1'b0;
    clear_colour = 3'($urandom);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
    tick;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!clear_done && n < 20500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(clear_done), 1);
    tick;
  endtask

  task automatic rand_pixel(input bit allow_off);
    if (allow_off && $urandom_range(9) == 0) begin
      x = 8'($urandom);
      y = 7'($urandom);
    end else begin
      x = 8'($urandom_range(FB_W - 1));
      y = 7'($urandom_range(FB_H - 1));
    end
    colour = 3'($urandom);
  endtask

  initial begin
`ifdef PLOT_CLIP_EN
    clip_on = 1'b1;
`else
    clip_on = 1'b0;
`endif
    repeat (3) tick;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_drop", 32'(drop_count), 0);

    // Single plot latency: visible two cycles after acceptance.
    tick;
    x = 8'd3; y = 7'd2; colour = 3'b101; plot = 1'b1;
    tick;
    plot = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("lat_we", 32'(mem_we), 1);
    check("lat_addr", 32'(mem_addr), 323);
    check("lat_data", 32'(mem_data), 5);
    wait_drain("lat_drain", 10);

    // Fill the FIFO behind a held scan-out read.
    rd_req = 1'b1;
    plot   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_pixel(1'b0);
      rd_addr = 15'($urandom);
      @(negedge clk);
      check("full_ready", 32'(ready), (i < 4) ? 1 : 0);
      tick;
    end
    plot   = 1'b0;
    rd_req = 1'b0;
    wait_drain("full_drain", 20);
    @(negedge clk);
    check("full_ready_after", 32'(ready), 1);
    tick;

    // Randomized plots interleaved with scan-out reads.
    for (int i = 0; i < 300; i++) begin
      plot    = 1'($urandom);
      rd_req  = ($urandom_range(3) == 0);
      rd_addr = 15'($urandom);
      rand_pixel(1'b1);
      tick;
    end
    plot   = 1'b0;
    rd_req = 1'b0;
    wait_drain("rand_drain", 100);
    check("rand_drop", 32'(drop_count), exp_drops);

    // Full-screen clear from idle.
    issue_clear(3'b010);
    wait_done("clr1_done");
    wait_drain("clr1_drain", 10);

    // Plots queued ahead of a clear; a repeated clear while pending is ignored.
    rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_pixel(1'b0);
      plot = 1'b1;
      tick;
    end
    plot = 1'b0;
    issue_clear(3'b110);
    clear = 1'b1;
    clear_colour = 3'b001;
    tick;
    clear  = 1'b0;
    rd_req = 1'b0;
    wait_done("clr2_done");
    wait_drain("clr2_drain", 10);

    // Reset in the middle of a fill.
    issue_clear(3'b111);
    begin
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 6000) begin
        @(negedge clk);
        hit = mem_we && (mem_addr == 15'd5000);
        n++;
      end
      check("abort_reach5000", 32'(hit), 1);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_we", 32'(mem_we), 0);
    check("abort_done", 32'(clear_done), 0);
    exp_q.delete();
    tick;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 1);
    check("abort_drop", 32'(drop_count), 0);
    begin
      bit seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        seen = seen | clear_done | mem_we;
      end
      check("abort_quiet", 32'(seen), 0);
    end
    tick;

    // Off-screen plots: dropped and counted when clipping is built in.
    x = 8'd160; y = 7'd5; colour = 3'b011; plot = 1'b1;
    tick;
    x = 8'd10; y = 7'd120;
    tick;
    plot = 1'b0;
    repeat (4) tick;
    @(negedge clk);
    check("clip_drop2", 32'(drop_count), exp_drops);
    tick;
    wait_drain("clip2_drain", 10);
    plot = 1'b1;
    for (int i = 0; i < 298; i++) begin
      x = (i % 2 == 0) ? 8'(FB_W + $urandom_range(95)) : 8'($urandom_range(FB_W - 1));
      y = (i % 2 == 0) ? 7'($urandom) : 7'(FB_H + $urandom_range(7));
      colour = 3'($urandom);
      tick;
    end
    plot = 1'b0;
    wait_drain("clip_sat_drain", 50);
    check("clip_drop_sat", 32'(drop_count), exp_drops);
    if (clip_on) check("clip_drop_255", 32'(drop_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
